operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
- Parametrised operand-entry sequencer for board-level arithmetic labs.
- Captures NUM_OPS operands of WIDTH bits from the switch bus, one per rising edge of the load input, into a flat register bank.
- Bank outputs feed per-operand hex display decoders; the registered sum feeds a result display.
- Supports one-shot and wrap (ring overwrite) modes, synchronous clear, and capture acknowledge and done flags.

Parameters:
- WIDTH, 8, bits per operand.
- NUM_OPS, 2, number of operands held (must be ≥1).
- Derived localparam IDX_W = max(1, clog2(NUM_OPS)); width of the operand index.
- Derived localparam SUM_W = WIDTH + max(1, clog2(NUM_OPS)); width of the sum.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  level from a debounced push-button; only its 0→1 transition (synchronously edge-detected) requests a capture.
- clear  in  1  synchronous clear, active-high.
- mode  in  1  0 = one-shot, 1 = wrap.
- data_in  in  WIDTH  value to capture.
- operands  out  NUM_OPS*WIDTH  operand k occupies bits [k*WIDTH +: WIDTH].
- index  out  IDX_W  slot the next capture writes.
- ack  out  1  one-cycle pulse in the cycle after a capture (same cycle the new operand is visible).
- done  out  1  high while all slots are filled.
- sum  out  SUM_W  registered, zero-extended sum of all operands.

Behaviour:
- Reset (reset=0, asynchronous):
  - operands=0, index=0, ack=0, done=0, sum=0.
  - State=FILL.
  - Edge-detect history load_q=0. A load held high through reset release therefore counts as one edge on the first clock.
- Edge detect: load_rise = load & ~load_q; load_q <= load every cycle, including clear cycles.
- States are FILL and FULL.
- Priority per cycle: clear > load_rise.
- clear=1:
  - All operands=0, index=0, done=0, state=FILL; sum becomes 0 the following cycle.
  - A coincident load_rise is discarded (no capture, no ack).
- FILL with load_rise:
  - operand[index] <= data_in; ack=1 next cycle.
  - If index==NUM_OPS-1: index<=0, state<=FULL, done<=1.
  - Otherwise index<=index+1.
- FULL with load_rise:
  - mode=0: ignored. No operand change, no ack; done stays 1.
  - mode=1: operand[0] <= data_in, ack=1.
    - NUM_OPS>1: index<=1, done<=0, state<=FILL. Remaining operands keep their old values until overwritten.
    - NUM_OPS=1: remain FULL, done=1, index=0.
- mode may change at any time; it is sampled only on a FULL load_rise.
- Latency:
  - Capture: edge cycle N → operand, index, done, ack updated at N+1.
  - sum reflects operands at N+2 (one register stage after the bank).
- Arithmetic: sum is an unsigned full-width add of all operands; it cannot overflow, since SUM_W bits suffice.
- Holding load high produces exactly one capture; re-arming requires load to return to 0 for at least one cycle.
- ack is never high for two consecutive cycles.

Test Plan:
- Reset, WIDTH=8, NUM_OPS=2, mode=0; load pulses with data_in=0x3C then 0xA5
  → operands=0xA53C, done=1, index=0, ack pulses twice, sum=0x0E1 two cycles after the second capture.
- From FULL, mode=0, third pulse with data_in=0xFF
  → no change: operands=0xA53C, ack stays 0.
- From FULL, mode=1, pulse with data_in=0x11
  → operands=0xA511, index=1, done=0; next pulse with 0x22 → operands=0x2211, done=1.
- clear asserted in the same cycle as a load_rise while index=1
  → operands=0, index=0, done=0, no ack; sum=0 one cycle later.
- load held high for 10 cycles → exactly one capture and one ack; reset asserted mid-hold then released with load still high → one capture on the first clock after release.
- NUM_OPS=4, WIDTH=4; capture 0xF four times
  → sum=0x3C (SUM_W=6), done=1; mode=1 with a fifth pulse of 0x1 → slot0=0x1, index=1, sum=0x2E.

Source files
------------

// File: rtl/operand_sequencer.sv
// Operand-entry sequencer: captures NUM_OPS operands from a switch bus on load
// rising edges into a flat bank, with one-shot/wrap modes and a registered sum.
module operand_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_OPS = 2,
    localparam int unsigned IDX_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
    localparam int unsigned SUM_W  = WIDTH + IDX_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load,
    input  logic                       clear,
    input  logic                       mode,
    input  logic [WIDTH-1:0]           data_in,
    output logic [NUM_OPS*WIDTH-1:0]   operands,
    output logic [IDX_W-1:0]           index,
    output logic                       ack,
    output logic                       done,
    output logic [SUM_W-1:0]           sum
);

    typedef enum logic {FILL, FULL} state_t;

    state_t                     state, state_next;
    logic                       load_q;
    logic                       load_rise;
    logic [NUM_OPS*WIDTH-1:0]   operands_next;
    logic [IDX_W-1:0]           index_next;
    logic                       ack_next;
    logic                       done_next;
    logic [SUM_W-1:0]           sum_total;
    logic [SUM_W-1:0]           sum_next;

    assign load_rise = load & ~load_q;

    // Zero-extended sum of the current bank; registered one stage later.
    always_comb begin
        sum_total = '0;
        for (int k = 0; k < int'(NUM_OPS); k++) begin
            sum_total = sum_total + SUM_W'(operands[k*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        state_next    = state;
        operands_next = operands;
        index_next    = index;
        ack_next      = 1'b0;
        done_next     = done;
        sum_next      = sum_total;

        if (clear) begin
            operands_next = '0;
            index_next    = '0;
            done_next     = 1'b0;
            state_next    = FILL;
            sum_next      = '0;
        end else if (load_rise) begin
            case (state)
                FILL: begin
                    operands_next[32'(index)*WIDTH +: WIDTH] = data_in;
                    ack_next = 1'b1;
                    if (index == IDX_W'(NUM_OPS - 1)) begin
                        index_next = '0;
                        state_next = FULL;
                        done_next  = 1'b1;
                    end else begin
                        index_next = index + IDX_W'(1);
                    end
                end
                FULL: begin
                    // One-shot mode ignores further edges; wrap mode restarts at slot 0.
                    if (mode) begin
                        operands_next[WIDTH-1:0] = data_in;
                        ack_next = 1'b1;
                        if (NUM_OPS > 1) begin
                            index_next = IDX_W'(1);
                            done_next  = 1'b0;
                            state_next = FILL;
                        end else begin
                            index_next = '0;
                            done_next  = 1'b1;
                        end
                    end
                end
                default: state_next = FILL;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= FILL;
            load_q   <= 1'b0;
            operands <= '0;
            index    <= '0;
            ack      <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
        end else begin
            state    <= state_next;
            load_q   <= load;
            operands <= operands_next;
            index    <= index_next;
            ack      <= ack_next;
            done     <= done_next;
            sum      <= sum_next;
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: table of per-cycle vectors on a 2x8 instance
// plus hand-written load-hold, reset-during-hold and 4x4 wrap sequences.
module tb_operand_sequencer;

    logic        clock;
    logic        reset;

    logic        load_a, clear_a, mode_a;
    logic [7:0]  data_a;
    logic [15:0] ops_a;
    logic [0:0]  idx_a;
    logic        ack_a, done_a;
    logic [8:0]  sum_a;

    logic        load_b, clear_b, mode_b;
    logic [3:0]  data_b;
    logic [15:0] ops_b;
    logic [1:0]  idx_b;
    logic        ack_b, done_b;
    logic [5:0]  sum_b;

    int checks = 0;
    int fails  = 0;

    operand_sequencer #(.WIDTH(8), .NUM_OPS(2)) dut_a (
        .clock(clock), .reset(reset), .load(load_a), .clear(clear_a), .mode(mode_a),
        .data_in(data_a), .operands(ops_a), .index(idx_a), .ack(ack_a),
        .done(done_a), .sum(sum_a)
    );

    operand_sequencer #(.WIDTH(4), .NUM_OPS(4)) dut_b (
        .clock(clock), .reset(reset), .load(load_b), .clear(clear_b), .mode(mode_b),
        .data_in(data_b), .operands(ops_b), .index(idx_b), .ack(ack_b),
        .done(done_b), .sum(sum_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ld;
        logic        clr;
        logic        md;
        logic [7:0]  d;
        logic [15:0] ops;
        logic        idx;
        logic        ack;
        logic        dn;
        logic [8:0]  sm;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic ld, input logic clr, input logic md,
                                input logic [7:0] d, input logic [15:0] ops,
                                input logic idx, input logic ack, input logic dn,
                                input logic [8:0] sm);
        vec_t v;
        v.ld = ld; v.clr = clr; v.md = md; v.d = d;
        v.ops = ops; v.idx = idx; v.ack = ack; v.dn = dn; v.sm = sm;
        vecs.push_back(v);
    endfunction

    initial begin
        int acks;
        logic prev_ack;

        //  ld clr md  data    operands  idx ack done sum
        add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 9'h000);
        add(1, 0, 0, 8'h3C, 16'h003C, 1, 1, 0, 9'h000);
        add(0, 0, 0, 8'h00, 16'h003C, 1, 0, 0, 9'h03C);
        add(1, 0, 0, 8'hA5, 16'hA53C, 0, 1, 1, 9'h03C);
        add(0, 0, 0, 8'h00, 16'hA53C, 0, 0, 1, 9'h0E1);
        add(1, 0, 0, 8'hFF, 16'hA53C, 0, 0, 1, 9'h0E1);
        add(0, 0, 1, 8'h00, 16'hA53C, 0, 0, 1, 9'h0E1);
        add(1, 0, 1, 8'h11, 16'hA511, 1, 1, 0, 9'h0E1);
        add(0, 0, 1, 8'h00, 16'hA511, 1, 0, 0, 9'h0B6);
        add(1, 0, 1, 8'h22, 16'h2211, 0, 1, 1, 9'h0B6);
        add(0, 0, 1, 8'h00, 16'h2211, 0, 0, 1, 9'h033);
        add(1, 0, 1, 8'h44, 16'h2244, 1, 1, 0, 9'h033);
        add(0, 0, 0, 8'h00, 16'h2244, 1, 0, 0, 9'h066);
        add(1, 1, 0, 8'h55, 16'h0000, 0, 0, 0, 9'h000);
        add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 9'h000);
        add(1, 0, 0, 8'h77, 16'h0077, 1, 1, 0, 9'h000);

        reset = 1'b0;
        load_a = 0; clear_a = 0; mode_a = 0; data_a = '0;
        load_b = 0; clear_b = 0; mode_b = 0; data_b = '0;
        repeat (2) @(negedge clock);
        check("rst_ops_a",  32'(ops_a),  0);
        check("rst_idx_a",  32'(idx_a),  0);
        check("rst_ack_a",  32'(ack_a),  0);
        check("rst_done_a", 32'(done_a), 0);
        check("rst_sum_a",  32'(sum_a),  0);
        check("rst_ops_b",  32'(ops_b),  0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            load_a = vecs[i].ld; clear_a = vecs[i].clr; mode_a = vecs[i].md; data_a = vecs[i].d;
            @(negedge clock);
            check($sformatf("v%0d.operands", i), 32'(ops_a),  32'(vecs[i].ops));
            check($sformatf("v%0d.index", i),    32'(idx_a),  32'(vecs[i].idx));
            check($sformatf("v%0d.ack", i),      32'(ack_a),  32'(vecs[i].ack));
            check($sformatf("v%0d.done", i),     32'(done_a), 32'(vecs[i].dn));
            check($sformatf("v%0d.sum", i),      32'(sum_a),  32'(vecs[i].sm));
        end

        // load stays high from the last vector: nine more cycles, no further capture
        acks = 0;
        prev_ack = ack_a;
        data_a = 8'hEE;
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            acks += int'(ack_a);
            check($sformatf("ack_not_back_to_back_%0d", c), 32'(prev_ack & ack_a), 0);
            prev_ack = ack_a;
        end
        check("hold_acks",     32'(acks),  0);
        check("hold_operands", 32'(ops_a), 32'h0077);
        check("hold_index",    32'(idx_a), 1);
        check("hold_sum",      32'(sum_a), 32'h077);

        // 4x4 instance: four captures of 0xF, then a wrap capture of 0x1
        for (int p = 0; p < 4; p++) begin
            load_b = 1'b1; data_b = 4'hF;
            @(negedge clock);
            check($sformatf("b_cap%0d_ack", p), 32'(ack_b), 1);
            load_b = 1'b0;
            @(negedge clock);
        end
        check("b_full_operands", 32'(ops_b),  32'hFFFF);
        check("b_full_done",     32'(done_b), 1);
        check("b_full_index",    32'(idx_b),  0);
        check("b_full_sum",      32'(sum_b),  32'h3C);
        mode_b = 1'b1; load_b = 1'b1; data_b = 4'h1;
        @(negedge clock);
        check("b_wrap_operands", 32'(ops_b),  32'hFFF1);
        check("b_wrap_index",    32'(idx_b),  1);
        check("b_wrap_done",     32'(done_b), 0);
        check("b_wrap_ack",      32'(ack_b),  1);
        load_b = 1'b0;
        @(negedge clock);
        check("b_wrap_sum",      32'(sum_b),  32'h2E);

        // reset asserted while load is still held, released with load high
        data_a = 8'h99;
        reset = 1'b0;
        #1;
        check("midrst_operands", 32'(ops_a),  0);
        check("midrst_index",    32'(idx_a),  0);
        check("midrst_done",     32'(done_a), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rel_operands", 32'(ops_a),  32'h0099);
        check("rel_ack",      32'(ack_a),  1);
        check("rel_index",    32'(idx_a),  1);
        @(negedge clock);
        check("rel_ack_drop", 32'(ack_a),  0);
        check("rel_sum",      32'(sum_a),  32'h099);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
